fft_mag_peak: RTL and testbench
===============================

# fft_mag_peak

Parametrised, fully pipelined magnitude stage for complex FFT output streams. Computes re²+im², or its integer square root when the square-root pipeline is compiled in. Applies a right-shift scale with saturation and tags every result with its bin index. Also tracks the per-frame peak (value and bin), reports it at frame end, and flags frames whose length disagrees with `FRAME_LEN`. It sits directly after the FFT core and feeds spectrum display and detection logic.

## Interface
- `IN_W`, 24: signed width of each real/imag input.
- `OUT_W`, 32: unsigned output width.
- `SHIFT`, 9: right shift applied before saturation; must be in 0..2*IN_W.
- `FRAME_LEN`, 1024: nominal bins per frame; must be ≥2. `BIN_W = $clog2(FRAME_LEN)`.
- `clk`, in, 1: single clock; all logic on the rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `in_valid`, in, 1: input sample qualifier.
- `in_real`, in, IN_W: two's-complement real part.
- `in_imag`, in, IN_W: two's-complement imaginary part.
- `in_eop`, in, 1: last sample of frame; only meaningful when `in_valid` is high.
- `out_valid`, out, 1: result qualifier.
- `out_data`, out, OUT_W: scaled magnitude (or magnitude²); 0 whenever `out_valid` is low.
- `out_bin`, out, BIN_W: bin index of `out_data`.
- `out_eop`, out, 1: frame end, aligned with the last result.
- `peak_valid`, out, 1: one-cycle pulse, peak report ready.
- `peak_data`, out, OUT_W: frame maximum; held until the next report.
- `peak_bin`, out, BIN_W: bin of the first occurrence of the maximum.
- `frame_err`, out, 1: one-cycle pulse, concurrent with `peak_valid`, when the frame length ≠ `FRAME_LEN`.

## Operation
- There is no backpressure. The block accepts one sample per cycle, and bubbles (`in_valid` low) propagate unchanged.
- Pipeline stages:
  - S1 registers the inputs.
  - S2 computes the squares, each 2*IN_W bits unsigned. The most-negative input is exact: (−2^(IN_W−1))² = 2^(2*IN_W−2).
  - S3 forms the sum, 2*IN_W+1 bits.
  - Optional sqrt stages follow.
  - SO shifts right by `SHIFT`, saturates to 2^OUT_W−1, and registers the outputs.
- Valid, eop and bin travel in a side pipeline of identical depth.
- Bin counter (input side):
  - Increments on each valid sample.
  - Clears to 0 after a sample with `in_eop`, or after the sample at bin FRAME_LEN−1.
  - A frame closes on either of these conditions, and the closing sample is marked eop internally.
  - An error is latched when the two conditions disagree: `in_eop` at bin < FRAME_LEN−1 (short frame), or bin FRAME_LEN−1 without `in_eop` (long frame, forced close).
- Peak tracker (output side):
  - The first valid result of a frame loads the running peak.
  - A later result replaces it only if strictly greater, so ties keep the lower bin.
  - On `out_eop` the tracker copies running value and bin to `peak_data`/`peak_bin`, pulses `peak_valid` the next cycle, and rearms.
  - The error flag is carried alongside eop and emitted as `frame_err` with `peak_valid`.
- Reset (asserted at any time, including mid-frame):
  - Clears the pipeline, the counter and the running peak.
  - Zeroes all outputs.
  - No peak report is issued for the interrupted frame.

## Timing
- Latency L from input to output, counted in clock edges:
  - L = 4 without sqrt.
  - L = 4 + (IN_W+1) with sqrt, i.e. 29 at defaults.
- `out_eop` appears in the same cycle as the result of the eop sample.
- `peak_valid`/`frame_err` appear at L+1 after the eop input.
- Back-to-back frames need no gap. A result with `out_eop` at cycle t and the next frame's first result at t+1 is legal.

## Configuration
- `FFT_MAG_SQRT_EN` defined:
  - Inserts IN_W+1 pipelined non-restoring square-root stages.
  - The sum is zero-extended to 2*IN_W+2 bits.
  - The result is floor(sqrt(re²+im²)), IN_W+1 bits, before shift/saturate.
- Undefined: the result is re²+im² before shift/saturate, and L = 4.

## Structure
- Package `fft_mag_pkg`:
  - `SQ_W`/`SUM_W`/`ROOT_W` width functions of IN_W.
  - `fft_mag_latency(IN_W)` returning L under the current macro setting.
  - Saturating-shift function.
- Sub-module `isqrt_pipe` (parametrised by input width):
  - One result bit per stage.
  - Carries a sideband bus of width BIN_W+2 (valid, eop, err).
  - Instantiated only under `FFT_MAG_SQRT_EN`.

## Test plan
- SHIFT=0, one sample (3,4):
  - With sqrt: `out_data`=5 at cycle L.
  - Without sqrt: `out_data`=25.
  - `out_bin`=0.
- Defaults, sample (−2^23, −2^23):
  - With sqrt: `out_data` = floor(11863283.2)>>9 = 23170.
  - Without sqrt: 2^47>>9 = 2^38, saturates to 0xFFFFFFFF.
- FRAME_LEN=8, SHIFT=0, full frame with bins 5 and 6 both at the maximum (e.g. (100,0)) and the rest (1,0): `peak_bin`=5, `peak_data`=100 (sqrt) or 10000, `peak_valid` at L+1 after eop, `frame_err`=0.
- FRAME_LEN=8, `in_eop` at bin 4 → `frame_err` pulses. Next frame with 9 samples and no eop → forced close at bin 7 with `frame_err`, and the 9th sample gets `out_bin`=0.
- Random `in_valid` bubbles across two back-to-back frames: `out_valid` pattern equals the input pattern delayed by L, `out_data`=0 in bubbles, peaks match a reference model.
- `rst_n` low for 1 cycle mid-frame: all outputs 0 next cycle, no `peak_valid` for the aborted frame, and the next frame starts at bin 0.

Source files
------------

// File: rtl/fft_mag_pkg.sv
// fft_mag_pkg: shared widths, sideband codes and helpers for fft_mag_peak.
// Honours FFT_MAG_SQRT_EN, which selects the square-root pipeline.
package fft_mag_pkg;

   // Per-sample sideband flags. A closing sample always carries an eop code,
   // so the error flag only needs to exist on eop.
   typedef enum logic [1:0] {
      SB_IDLE    = 2'd0,
      SB_DATA    = 2'd1,
      SB_EOP     = 2'd2,
      SB_EOP_ERR = 2'd3
   } sb_code_e;

`ifdef FFT_MAG_SQRT_EN
   localparam bit SQRT_EN = 1'b1;
`else
   localparam bit SQRT_EN = 1'b0;
`endif

   function automatic int sq_w(input int in_w);
      return 2 * in_w;
   endfunction

   function automatic int sum_w(input int in_w);
      return 2 * in_w + 1;
   endfunction

   function automatic int root_w(input int in_w);
      return in_w + 1;
   endfunction

   // Input-to-output latency in clock edges for the current build.
   function automatic int fft_mag_latency(input int in_w);
      return 4 + (SQRT_EN ? root_w(in_w) : 0);
   endfunction

   // Right shift by sh, then clamp to the largest ow-bit unsigned value.
   function automatic logic [63:0] sat_shift(input logic [63:0] v, input int sh, input int ow);
      logic [63:0] s;
      logic [63:0] m;
      s = v >> sh;
      m = (ow >= 64) ? '1 : ((64'd1 << ow) - 64'd1);
      return (s > m) ? m : s;
   endfunction

endpackage

// File: rtl/isqrt_pipe.sv
// isqrt_pipe: pipelined non-restoring integer square root, one result bit
// per stage, with a sideband bus delayed alongside. Only built when
// FFT_MAG_SQRT_EN is defined.
`ifdef FFT_MAG_SQRT_EN
module isqrt_pipe #(
   parameter  int D_W  = 49,
   parameter  int SB_W = 12,
   localparam int N    = (D_W + 1) / 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [D_W-1:0]  d,
   input  logic [SB_W-1:0] sb_in,
   output logic [N-1:0]    root,
   output logic [SB_W-1:0] sb_out
);
   // Partial remainder needs two bits of headroom over the root for the
   // shifted-in radicand pair plus a sign bit.
   localparam int RW = N + 3;

   logic signed [RW-1:0] rem   [N];
   logic        [N-1:0]  q     [N];
   logic        [2*N-1:0] rad  [N];
   logic        [SB_W-1:0] sb  [N];

   logic signed [RW-1:0] rem_nx [N];
   logic        [N-1:0]  q_nx   [N];
   logic        [2*N-1:0] rad_in [N];

   // Each stage consumes the top radicand pair and decides one root bit.
   always_comb begin
      for (int i = 0; i < N; i++) begin
         logic signed [RW-1:0] r_in;
         logic signed [RW-1:0] r_sh;
         logic        [N-1:0]  q_in;
         r_in      = (i == 0) ? '0 : rem[i-1];
         q_in      = (i == 0) ? '0 : q[i-1];
         rad_in[i] = (i == 0) ? (2*N)'(d) : rad[i-1];
         r_sh      = (r_in <<< 2) + $signed({{(RW-2){1'b0}}, rad_in[i][2*N-1 -: 2]});
         if (!r_in[RW-1])
            rem_nx[i] = r_sh - $signed({1'b0, q_in, 2'b01});
         else
            rem_nx[i] = r_sh + $signed({1'b0, q_in, 2'b11});
         q_nx[i] = {q_in[N-2:0], ~rem_nx[i][RW-1]};
      end
   end

   // Stage registers for remainder, partial root, radicand and sideband.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N; i++) begin
            rem[i] <= '0;
            q[i]   <= '0;
            rad[i] <= '0;
            sb[i]  <= '0;
         end
      end else begin
         for (int i = 0; i < N; i++) begin
            rem[i] <= rem_nx[i];
            q[i]   <= q_nx[i];
            rad[i] <= rad_in[i] << 2;
            sb[i]  <= (i == 0) ? sb_in : sb[i-1];
         end
      end
   end

   assign root   = q[N-1];
   assign sb_out = sb[N-1];

endmodule
`endif

// File: rtl/fft_mag_peak.sv
// fft_mag_peak: pipelined |X|^2 (or |X| with FFT_MAG_SQRT_EN) with shift and
// saturation, bin tagging, frame length checking and per-frame peak report.
module fft_mag_peak
   import fft_mag_pkg::*;
#(
   parameter  int IN_W      = 24,
   parameter  int OUT_W     = 32,
   parameter  int SHIFT     = 9,
   parameter  int FRAME_LEN = 1024,
   localparam int BIN_W     = $clog2(FRAME_LEN)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [IN_W-1:0]  in_real,
   input  logic [IN_W-1:0]  in_imag,
   input  logic             in_eop,
   output logic             out_valid,
   output logic [OUT_W-1:0] out_data,
   output logic [BIN_W-1:0] out_bin,
   output logic             out_eop,
   output logic             peak_valid,
   output logic [OUT_W-1:0] peak_data,
   output logic [BIN_W-1:0] peak_bin,
   output logic             frame_err
);
   localparam int SQ_W  = sq_w(IN_W);
   localparam int SUM_W = sum_w(IN_W);
   localparam int SB_W  = BIN_W + 2;
`ifdef FFT_MAG_SQRT_EN
   localparam int RES_W = root_w(IN_W);
`else
   localparam int RES_W = SUM_W;
`endif

   logic [BIN_W-1:0]       cnt;
   logic                   last, close;
   sb_code_e               code_in;
   logic signed [IN_W-1:0] re1, im1;
   logic signed [SQ_W-1:0] re_x, im_x;
   logic [SQ_W-1:0]        sq_re, sq_im;
   logic [SUM_W-1:0]       sum;
   logic [SB_W-1:0]        sb_pipe [3];
   logic [RES_W-1:0]       res;
   logic [SB_W-1:0]        sb_res;
   sb_code_e               code_o;
   logic                   v_o, out_err;
   logic                   have;
   logic [OUT_W-1:0]       run_val, cand_val;
   logic [BIN_W-1:0]       run_bin, cand_bin;

   // Classify the incoming sample: a frame closes on in_eop or on the last
   // nominal bin, and it is in error when those two disagree.
   always_comb begin
      last    = (cnt == BIN_W'(FRAME_LEN - 1));
      close   = in_eop | last;
      code_in = SB_IDLE;
      if (in_valid)
         code_in = !close ? SB_DATA : ((in_eop ^ last) ? SB_EOP_ERR : SB_EOP);
   end

   // Input-side bin counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt <= '0;
      else if (in_valid)
         cnt <= close ? '0 : cnt + 1'b1;
   end

   assign re_x = SQ_W'(re1);
   assign im_x = SQ_W'(im1);

   // S1 input regs, S2 squares, S3 sum, with the sideband in lockstep.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         re1   <= '0;
         im1   <= '0;
         sq_re <= '0;
         sq_im <= '0;
         sum   <= '0;
         for (int i = 0; i < 3; i++) sb_pipe[i] <= '0;
      end else begin
         re1        <= in_real;
         im1        <= in_imag;
         sq_re      <= $unsigned(re_x * re_x);
         sq_im      <= $unsigned(im_x * im_x);
         sum        <= SUM_W'(sq_re) + SUM_W'(sq_im);
         sb_pipe[0] <= {code_in, cnt};
         sb_pipe[1] <= sb_pipe[0];
         sb_pipe[2] <= sb_pipe[1];
      end
   end

`ifdef FFT_MAG_SQRT_EN
   isqrt_pipe #(.D_W(SUM_W), .SB_W(SB_W)) u_isqrt (
      .clk    (clk),
      .rst_n  (rst_n),
      .d      (sum),
      .sb_in  (sb_pipe[2]),
      .root   (res),
      .sb_out (sb_res)
   );
`else
   assign res    = sum;
   assign sb_res = sb_pipe[2];
`endif

   assign code_o = sb_code_e'(sb_res[SB_W-1 -: 2]);
   assign v_o    = (code_o != SB_IDLE);

   // SO: shift/saturate and register outputs; everything is zero in bubbles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_bin   <= '0;
         out_eop   <= 1'b0;
         out_err   <= 1'b0;
      end else begin
         out_valid <= v_o;
         out_data  <= v_o ? OUT_W'(sat_shift(64'(res), SHIFT, OUT_W)) : '0;
         out_bin   <= v_o ? sb_res[BIN_W-1:0] : '0;
         out_eop   <= (code_o == SB_EOP) || (code_o == SB_EOP_ERR);
         out_err   <= (code_o == SB_EOP_ERR);
      end
   end

   // Running maximum including the current result; ties keep the older bin.
   always_comb begin
      cand_val = run_val;
      cand_bin = run_bin;
      if (!have || out_data > run_val) begin
         cand_val = out_data;
         cand_bin = out_bin;
      end
   end

   // Peak tracker: accumulate over the frame, report and rearm on out_eop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         have       <= 1'b0;
         run_val    <= '0;
         run_bin    <= '0;
         peak_valid <= 1'b0;
         peak_data  <= '0;
         peak_bin   <= '0;
         frame_err  <= 1'b0;
      end else begin
         peak_valid <= 1'b0;
         frame_err  <= 1'b0;
         if (out_valid) begin
            if (out_eop) begin
               peak_data  <= cand_val;
               peak_bin   <= cand_bin;
               peak_valid <= 1'b1;
               frame_err  <= out_err;
               have       <= 1'b0;
            end else begin
               run_val <= cand_val;
               run_bin <= cand_bin;
               have    <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_fft_mag_peak.sv
// tb_fft_mag_peak: directed bench for fft_mag_peak. Instance a uses default
// parameters; instance b uses FRAME_LEN=8, SHIFT=0 and is also checked every
// cycle against a small behavioural model. Honours FFT_MAG_SQRT_EN.
module tb_fft_mag_peak;

`ifdef FFT_MAG_SQRT_EN
   localparam int L = 29;
   localparam longint EXP34  = 5;
   localparam longint EXPNEG = 23170;
   localparam longint EXP100 = 100;
   localparam longint EXP6   = 6;
   localparam longint EXP10  = 10;
`else
   localparam int L = 4;
   localparam longint EXP34  = 25;
   localparam longint EXPNEG = 64'hFFFF_FFFF;
   localparam longint EXP100 = 10000;
   localparam longint EXP6   = 36;
   localparam longint EXP10  = 100;
`endif

   logic clk, rst_n;

   logic        a_in_valid, a_in_eop;
   logic [23:0] a_in_real, a_in_imag;
   logic        a_out_valid, a_out_eop, a_peak_valid, a_frame_err;
   logic [31:0] a_out_data, a_peak_data;
   logic [9:0]  a_out_bin, a_peak_bin;

   logic        b_in_valid, b_in_eop;
   logic [23:0] b_in_real, b_in_imag;
   logic        b_out_valid, b_out_eop, b_peak_valid, b_frame_err;
   logic [31:0] b_out_data, b_peak_data;
   logic [2:0]  b_out_bin, b_peak_bin;

   fft_mag_peak dut_a (
      .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_real(a_in_real),
      .in_imag(a_in_imag), .in_eop(a_in_eop), .out_valid(a_out_valid),
      .out_data(a_out_data), .out_bin(a_out_bin), .out_eop(a_out_eop),
      .peak_valid(a_peak_valid), .peak_data(a_peak_data), .peak_bin(a_peak_bin),
      .frame_err(a_frame_err));

   fft_mag_peak #(.IN_W(24), .OUT_W(32), .SHIFT(0), .FRAME_LEN(8)) dut_b (
      .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_real(b_in_real),
      .in_imag(b_in_imag), .in_eop(b_in_eop), .out_valid(b_out_valid),
      .out_data(b_out_data), .out_bin(b_out_bin), .out_eop(b_out_eop),
      .peak_valid(b_peak_valid), .peak_data(b_peak_data), .peak_bin(b_peak_bin),
      .frame_err(b_frame_err));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec, n_err, cyc;

   // expected outputs of instance b, indexed by cycle modulo 128
   bit     e_v [128];
   longint e_d [128];
   int     e_b [128];
   bit     e_e [128];
   bit     e_pv[128];
   longint e_pd[128];
   int     e_pb[128];
   bit     e_fe[128];
   longint held_pd;
   int     held_pb;
   int     m_cnt;
   bit     m_have;
   longint m_run;
   int     m_rbin;

   function automatic longint isqrt(input longint s);
      longint r = 0;
      for (int b = 31; b >= 0; b--) begin
         longint t = r | (longint'(1) << b);
         if (t * t <= s) r = t;
      end
      return r;
   endfunction

   function automatic longint mag(input int re, input int im);
      longint s = longint'(re) * re + longint'(im) * im;
`ifdef FFT_MAG_SQRT_EN
      s = isqrt(s);
`endif
      if (s > 64'hFFFF_FFFF) s = 64'hFFFF_FFFF;
      return s;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s cyc=%0d: got %0d expected %0d", tag, cyc, obs, exp);
      end
   endtask

   task automatic m_reset();
      for (int i = 0; i < 128; i++) begin
         e_v[i] = 0; e_d[i] = 0; e_b[i] = 0; e_e[i] = 0;
         e_pv[i] = 0; e_pd[i] = 0; e_pb[i] = 0; e_fe[i] = 0;
      end
      held_pd = 0; held_pb = 0; m_cnt = 0; m_have = 0; m_run = 0; m_rbin = 0;
   endtask

   // Model: sample presented before edge e shows up after edge e+L-1,
   // its frame's peak report after edge e+L.
   task automatic model_in(input bit v, input int re, input int im, input bit eop, input int e);
      int oi, pi;
      bit last, close;
      longint m;
      if (v) begin
         oi = (e + L - 1) % 128;
         pi = (e + L) % 128;
         m = mag(re, im);
         last = (m_cnt == 7);
         close = eop || last;
         e_v[oi] = 1; e_d[oi] = m; e_b[oi] = m_cnt; e_e[oi] = close;
         if (!m_have || m > m_run) begin m_run = m; m_rbin = m_cnt; end
         m_have = 1;
         if (close) begin
            e_pv[pi] = 1; e_pd[pi] = m_run; e_pb[pi] = m_rbin; e_fe[pi] = (eop != last);
            m_have = 0; m_cnt = 0;
         end else begin
            m_cnt++;
         end
      end
   endtask

   task automatic check_cycle();
      int idx = cyc % 128;
      if (e_pv[idx]) begin held_pd = e_pd[idx]; held_pb = e_pb[idx]; end
      chk("out_valid",  64'(b_out_valid),  64'(e_v[idx]));
      chk("out_data",   64'(b_out_data),   64'(e_d[idx]));
      chk("out_bin",    64'(b_out_bin),    64'(e_b[idx]));
      chk("out_eop",    64'(b_out_eop),    64'(e_e[idx]));
      chk("peak_valid", 64'(b_peak_valid), 64'(e_pv[idx]));
      chk("peak_data",  64'(b_peak_data),  64'(held_pd));
      chk("peak_bin",   64'(b_peak_bin),   64'(held_pb));
      chk("frame_err",  64'(b_frame_err),  64'(e_fe[idx]));
      e_v[idx] = 0; e_d[idx] = 0; e_b[idx] = 0; e_e[idx] = 0;
      e_pv[idx] = 0; e_pd[idx] = 0; e_pb[idx] = 0; e_fe[idx] = 0;
   endtask

   task automatic step(input bit v, input int re, input int im, input bit eop);
      b_in_valid = v;
      b_in_real  = re[23:0];
      b_in_imag  = im[23:0];
      b_in_eop   = eop;
      model_in(v, re, im, eop, cyc + 1);
      @(posedge clk);
      cyc++;
      #1;
      check_cycle();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0);
   endtask

   initial begin
      n_vec = 0; n_err = 0; cyc = 0;
      m_reset();
      rst_n = 1'b0;
      a_in_valid = 0; a_in_eop = 0; a_in_real = '0; a_in_imag = '0;
      b_in_valid = 0; b_in_eop = 0; b_in_real = '0; b_in_imag = '0;

      // reset state
      idle(2);
      chk("rst_a_out_valid",  64'(a_out_valid),  64'd0);
      chk("rst_a_out_data",   64'(a_out_data),   64'd0);
      chk("rst_a_peak_valid", 64'(a_peak_valid), 64'd0);
      chk("rst_b_out_valid",  64'(b_out_valid),  64'd0);
      chk("rst_b_peak_data",  64'(b_peak_data),  64'd0);
      chk("rst_b_frame_err",  64'(b_frame_err),  64'd0);
      rst_n = 1'b1;
      idle(1);

      // (3,4) on b as a single-sample frame; most-negative pair on a
      a_in_valid = 1; a_in_real = 24'h800000; a_in_imag = 24'h800000;
      step(1, 3, 4, 1);
      a_in_valid = 0; a_in_real = '0; a_in_imag = '0;
      idle(L - 1);
      chk("d34_valid", 64'(b_out_valid), 64'd1);
      chk("d34_data",  64'(b_out_data),  64'(EXP34));
      chk("d34_bin",   64'(b_out_bin),   64'd0);
      chk("neg_valid", 64'(a_out_valid), 64'd1);
      chk("neg_data",  64'(a_out_data),  64'(EXPNEG));
      chk("neg_bin",   64'(a_out_bin),   64'd0);
      idle(1);
      chk("d34_peak_valid", 64'(b_peak_valid), 64'd1);
      chk("d34_short_err",  64'(b_frame_err),  64'd1);

      // full frame, tie between bins 5 and 6
      for (int i = 0; i < 8; i++) step(1, (i == 5 || i == 6) ? 100 : 1, 0, i == 7);
      idle(L);
      chk("tie_peak_valid", 64'(b_peak_valid), 64'd1);
      chk("tie_peak_bin",   64'(b_peak_bin),   64'd5);
      chk("tie_peak_data",  64'(b_peak_data),  64'(EXP100));
      chk("tie_frame_err",  64'(b_frame_err),  64'd0);
      idle(2);
      chk("peak_hold", 64'(b_peak_data), 64'(EXP100));

      // short frame: eop at bin 4
      for (int i = 0; i < 5; i++) step(1, i + 2, 0, i == 4);
      idle(L);
      chk("short_peak_valid", 64'(b_peak_valid), 64'd1);
      chk("short_frame_err",  64'(b_frame_err),  64'd1);
      chk("short_peak_bin",   64'(b_peak_bin),   64'd4);
      chk("short_peak_data",  64'(b_peak_data),  64'(EXP6));

      // long frame: 9 samples, no eop -> forced close at bin 7
      for (int i = 0; i < 9; i++) step(1, 10, 0, 0);
      idle(L - 1);
      chk("long_frame_err",  64'(b_frame_err),  64'd1);
      chk("long_peak_valid", 64'(b_peak_valid), 64'd1);
      chk("long_peak_bin",   64'(b_peak_bin),   64'd0);
      chk("long_peak_data",  64'(b_peak_data),  64'(EXP10));
      chk("ninth_valid",     64'(b_out_valid),  64'd1);
      chk("ninth_bin",       64'(b_out_bin),    64'd0);
      chk("ninth_eop",       64'(b_out_eop),    64'd0);
      for (int i = 1; i < 8; i++) step(1, 5, 0, i == 7);
      idle(L + 1);

      // two back-to-back frames with random bubbles
      begin
         int n = 0;
         while (n < 16) begin
            if ($urandom_range(0, 2) == 0) begin
               step(0, 0, 0, 0);
            end else begin
               step(1, int'($urandom_range(0, 4000)) - 2000,
                       int'($urandom_range(0, 4000)) - 2000, (n % 8) == 7);
               n++;
            end
         end
      end
      idle(L + 2);

      // reset for one cycle mid-frame
      for (int i = 0; i < 3; i++) step(1, 7, 7, 0);
      rst_n = 1'b0;
      m_reset();
      step(0, 0, 0, 0);
      chk("mid_rst_out_valid",  64'(b_out_valid),  64'd0);
      chk("mid_rst_out_data",   64'(b_out_data),   64'd0);
      chk("mid_rst_peak_data",  64'(b_peak_data),  64'd0);
      chk("mid_rst_peak_valid", 64'(b_peak_valid), 64'd0);
      rst_n = 1'b1;
      idle(L + 2);
      step(1, 0, 1, 0);
      idle(L - 1);
      chk("post_rst_valid", 64'(b_out_valid), 64'd1);
      chk("post_rst_bin",   64'(b_out_bin),   64'd0);
      for (int i = 1; i < 8; i++) step(1, i, 1, i == 7);
      idle(L + 2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
